rd_line_sched: RTL and testbench

Multi-channel DDR line-read request scheduler for the video/PCIe read path, generalising the single-channel prefetch logic to CH_NUM independent read buffers sharing one DDR read port. Each channel keeps its own frame sync, bank lock, line counter and fill-level watermark hysteresis. A round-robin arbiter issues one full-line read at a time and demultiplexes returned beats to the owning channel's buffer write enable. The block sits in the ddr_clk domain between the per-channel line RAMs and the DDR read command interface.

---
 rtl/rd_line_sched_pkg.sv | 14 +
 rtl/rd_line_sched_arb.sv | 31 +++
 rtl/rd_line_sched.sv | 177 +++++++++++++++++
 tb/tb_rd_line_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_line_sched_pkg.sv
// Shared types and constants for the multi-channel DDR line-read scheduler.
package rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2,
    ST_DATA = 2'd3
  } sched_state_t;

  // Width of each per-channel line counter on ch_line.
  localparam int LINE_W = 12;

endpackage

// File: rtl/rd_line_sched_arb.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module rd_rr_arb #(
  parameter int CH_NUM = 2,
  parameter int IDX_W  = 1
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [CH_NUM-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // Walk channels last_grant+1 .. last_grant (wrapping); first requester wins.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= CH_NUM; i++) begin
      k = int'(last_grant) + i;
      if (k >= CH_NUM) k = k - CH_NUM;
      if (!gnt_vld && req[k[IDX_W-1:0]]) begin
        gnt_vld             = 1'b1;
        gnt[k[IDX_W-1:0]]   = 1'b1;
        gnt_idx             = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rd_line_sched.sv
// Multi-channel line-read scheduler: per-channel frame/line tracking with
// fill-level hysteresis, one full-line DDR read in flight at a time.
//
// state | meaning
// IDLE  | waiting for any eligible channel
// ARB   | pick channel round-robin, latch address
// REQ   | ddr_rreq held until ddr_rrdy
// DATA  | beats routed to granted channel until ddr_rdone rises
module rd_line_sched
  import rd_sched_pkg::*;
#(
  parameter int          CH_NUM      = 2,
  parameter int          ADDR_WIDTH  = 27,
  parameter int          LEN_WIDTH   = 16,
  parameter int          LINE_LEN    = 240,
  parameter int          LINE_STEP   = 1920,
  parameter int          V_NUM       = 1080,
  parameter int          BANK_SHIFT  = 19,
  parameter logic [31:0] ADDR_OFFSET = 32'h0,
  parameter logic [31:0] CH_STRIDE   = 32'h0010_0000,
  parameter int          FILL_WIDTH  = 10,
  parameter int          HIGH_WATER  = 640,
  parameter int          LOW_WATER   = 320
) (
  input  logic                         ddr_clk,
  input  logic                         ddr_rst,
  input  logic                         init_done,
  input  logic [CH_NUM-1:0]            ch_en,
  input  logic [CH_NUM-1:0]            ch_fsync,
  input  logic [CH_NUM-1:0]            ch_frame_bit,
  input  logic [CH_NUM*FILL_WIDTH-1:0] ch_fill,
  output logic                         ddr_rreq,
  output logic [ADDR_WIDTH-1:0]        ddr_raddr,
  output logic [LEN_WIDTH-1:0]         ddr_rd_len,
  input  logic                         ddr_rrdy,
  input  logic                         ddr_rdone,
  input  logic                         ddr_rdata_en,
  output logic [CH_NUM-1:0]            ch_wr_en,
  output logic [CH_NUM*LINE_W-1:0]     ch_line,
  output logic [CH_NUM-1:0]            ch_frame_done,
  output logic                         err_overrun
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  sched_state_t          state;
  logic [CH_NUM-1:0]     fsync_d, fs_rise, pf_en, bank, eligible, gnt_oh, arb_gnt;
  logic [LINE_W-1:0]     line_cnt [CH_NUM];
  logic [ADDR_WIDTH-1:0] addr_acc [CH_NUM];
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [IDX_W-1:0]      last_grant, arb_idx;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  arb_vld, stale, rdone_d, rdone_rise, hit_fs, busy, beat_ok, live_done;

  assign ddr_rd_len = LEN_WIDTH'(LINE_LEN);
  assign fs_rise    = ch_fsync & ~fsync_d;
  assign rdone_rise = ddr_rdone & ~rdone_d;
  assign busy       = (state == ST_REQ) || (state == ST_DATA);
  // A frame start on the owning channel invalidates the beat in that same cycle too.
  assign hit_fs     = |(fs_rise & gnt_oh);
  assign beat_ok    = ddr_rdata_en & busy & ~stale & ~hit_fs &
                      (beat_cnt < LEN_WIDTH'(LINE_LEN));
  assign ch_wr_en   = beat_ok ? gnt_oh : '0;
  assign live_done  = (state == ST_DATA) & rdone_rise & ~stale;

  // Per-channel eligibility and line counter fan-out.
  always_comb begin
    eligible = '0;
    ch_line  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      eligible[c] = init_done & ch_en[c] & pf_en[c] & (line_cnt[c] < LINE_W'(V_NUM));
      ch_line[c*LINE_W +: LINE_W] = line_cnt[c];
    end
  end

  rd_rr_arb #(
    .CH_NUM (CH_NUM),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req        (eligible),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_vld    (arb_vld)
  );

  // Line start address of the channel the arbiter is currently picking.
  always_comb begin
    base_addr = ADDR_WIDTH'(ADDR_OFFSET)
              + ADDR_WIDTH'(CH_STRIDE) * ADDR_WIDTH'(arb_idx)
              + (ADDR_WIDTH'(bank[arb_idx]) << BANK_SHIFT)
              + addr_acc[arb_idx];
  end

  // Per-channel frame sync, bank lock, watermark hysteresis and line progress.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      fsync_d       <= '0;
      pf_en         <= '1;
      bank          <= '0;
      ch_frame_done <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        line_cnt[c] <= '0;
        addr_acc[c] <= '0;
      end
    end else begin
      fsync_d       <= ch_fsync;
      ch_frame_done <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (fs_rise[c]) begin
          line_cnt[c] <= '0;
          addr_acc[c] <= '0;
          bank[c]     <= ~ch_frame_bit[c];
          pf_en[c]    <= 1'b1;
        end else begin
          if (ch_fill[c*FILL_WIDTH +: FILL_WIDTH] >= FILL_WIDTH'(HIGH_WATER))
            pf_en[c] <= 1'b0;
          else if (ch_fill[c*FILL_WIDTH +: FILL_WIDTH] <= FILL_WIDTH'(LOW_WATER))
            pf_en[c] <= 1'b1;
          if (live_done && gnt_oh[c]) begin
            line_cnt[c] <= line_cnt[c] + 1'b1;
            addr_acc[c] <= addr_acc[c] + ADDR_WIDTH'(LINE_STEP);
            if (line_cnt[c] == LINE_W'(V_NUM - 1)) ch_frame_done[c] <= 1'b1;
          end
        end
      end
    end
  end

  // Transaction FSM with beat accounting and overrun detection.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state       <= ST_IDLE;
      ddr_rreq    <= 1'b0;
      ddr_raddr   <= '0;
      last_grant  <= IDX_W'(CH_NUM - 1);
      gnt_oh      <= '0;
      stale       <= 1'b0;
      beat_cnt    <= '0;
      rdone_d     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rdone_d <= ddr_rdone;
      if (ddr_rdata_en && (!busy || beat_cnt >= LEN_WIDTH'(LINE_LEN)))
        err_overrun <= 1'b1;
      if (ddr_rdata_en && busy && beat_cnt < LEN_WIDTH'(LINE_LEN))
        beat_cnt <= beat_cnt + 1'b1;
      if (busy && hit_fs)
        stale <= 1'b1;
      case (state)
        ST_IDLE: if (|eligible) state <= ST_ARB;
        ST_ARB: begin
          if (arb_vld) begin
            gnt_oh     <= arb_gnt;
            last_grant <= arb_idx;
            ddr_raddr  <= base_addr;
            ddr_rreq   <= 1'b1;
            stale      <= 1'b0;
            beat_cnt   <= '0;
            state      <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (ddr_rrdy) begin
            ddr_rreq <= 1'b0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: if (rdone_rise) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_line_sched.sv
// Directed bench for rd_line_sched: 2 channels, 4-beat lines, 4-line frames.
module tb_rd_line_sched;

  localparam int CH   = 2;
  localparam int AW   = 27;
  localparam int LLEN = 4;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst, init_done, ddr_rrdy, ddr_rdone, ddr_rdata_en;
  logic [CH-1:0] ch_en, ch_fsync, ch_frame_bit;
  logic [19:0]   ch_fill;
  logic          ddr_rreq, err_overrun;
  logic [AW-1:0] ddr_raddr;
  logic [15:0]   ddr_rd_len;
  logic [CH-1:0] ch_wr_en, ch_frame_done;
  logic [23:0]   ch_line;

  int vec_cnt = 0;
  int err_cnt = 0;

  rd_line_sched #(
    .CH_NUM   (CH),
    .LINE_LEN (LLEN),
    .V_NUM    (4)
  ) dut (
    .ddr_clk       (ddr_clk),
    .ddr_rst       (ddr_rst),
    .init_done     (init_done),
    .ch_en         (ch_en),
    .ch_fsync      (ch_fsync),
    .ch_frame_bit  (ch_frame_bit),
    .ch_fill       (ch_fill),
    .ddr_rreq      (ddr_rreq),
    .ddr_raddr     (ddr_raddr),
    .ddr_rd_len    (ddr_rd_len),
    .ddr_rrdy      (ddr_rrdy),
    .ddr_rdone     (ddr_rdone),
    .ddr_rdata_en  (ddr_rdata_en),
    .ch_wr_en      (ch_wr_en),
    .ch_line       (ch_line),
    .ch_frame_done (ch_frame_done),
    .err_overrun   (err_overrun)
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic do_reset();
    ddr_rst = 1'b1; init_done = 1'b1; ddr_rrdy = 1'b0; ddr_rdone = 1'b0;
    ddr_rdata_en = 1'b0; ch_en = '0; ch_fsync = '0; ch_frame_bit = '0; ch_fill = '0;
    tick(); tick();
    ddr_rst = 1'b0;
  endtask

  task automatic wait_rreq(output int cyc);
    cyc = 0;
    while (!ddr_rreq && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!ddr_rreq) cyc = -1;
  endtask

  // One complete line read as seen from the DDR side.
  task automatic serve(input int beats, output logic [AW-1:0] addr, output logic [CH-1:0] wr,
                       output logic [CH-1:0] fd, output int cyc);
    wr = '0; fd = '0; addr = '1;
    wait_rreq(cyc);
    if (cyc >= 0) begin
      addr = ddr_raddr;
      ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
      for (int b = 0; b < beats; b++) begin
        ddr_rdata_en = 1'b1; #1; wr = wr | ch_wr_en; tick();
      end
      ddr_rdata_en = 1'b0; ddr_rdone = 1'b1; tick();
      fd = ch_frame_done; ddr_rdone = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [AW-1:0] a; logic [CH-1:0] w, f; int cyc; logic seen;
    ddr_rst = 1'b1; init_done = 1'b0; ddr_rrdy = 1'b0; ddr_rdone = 1'b0;
    ddr_rdata_en = 1'b0; ch_en = 2'b11; ch_fsync = '0; ch_frame_bit = '0; ch_fill = '0;
    tick(); tick();
    vec_cnt++; if (ddr_rreq !== 1'b0) begin err_cnt++; $display("FAIL rst_rreq: got %b want 0", ddr_rreq); end
    vec_cnt++; if (ddr_raddr !== '0) begin err_cnt++; $display("FAIL rst_raddr: got %h want 0", ddr_raddr); end
    vec_cnt++; if (ch_wr_en !== '0) begin err_cnt++; $display("FAIL rst_wr_en: got %b want 00", ch_wr_en); end
    vec_cnt++; if (ch_line !== '0) begin err_cnt++; $display("FAIL rst_line: got %h want 0", ch_line); end
    vec_cnt++; if (ch_frame_done !== '0) begin err_cnt++; $display("FAIL rst_fdone: got %b want 00", ch_frame_done); end
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b want 0", err_overrun); end
    vec_cnt++; if (ddr_rd_len !== 16'd4) begin err_cnt++; $display("FAIL rd_len: got %0d want 4", ddr_rd_len); end
    ddr_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen = seen | ddr_rreq; end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL no_init_req: got %b want 0", seen); end
    init_done = 1'b1;
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL first_latency: got %0d want 2", cyc); end
    vec_cnt++; if (a !== 27'h0) begin err_cnt++; $display("FAIL first_addr: got %h want 0", a); end
    vec_cnt++; if (w !== 2'b01) begin err_cnt++; $display("FAIL first_grant: got %b want 01", w); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a; logic [CH-1:0] w, f; int cyc;
    do_reset();
    ch_en = 2'b11;
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h0) begin err_cnt++; $display("FAIL rr_addr0: got %h want 0", a); end
    vec_cnt++; if (w !== 2'b01) begin err_cnt++; $display("FAIL rr_gnt0: got %b want 01", w); end
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL rr_gap: got %0d want 2", cyc); end
    vec_cnt++; if (a !== 27'h100000) begin err_cnt++; $display("FAIL rr_addr1: got %h want 100000", a); end
    vec_cnt++; if (w !== 2'b10) begin err_cnt++; $display("FAIL rr_gnt1: got %b want 10", w); end
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h780) begin err_cnt++; $display("FAIL rr_addr2: got %h want 780", a); end
    vec_cnt++; if (w !== 2'b01) begin err_cnt++; $display("FAIL rr_gnt2: got %b want 01", w); end
    vec_cnt++; if (ch_line !== {12'd1, 12'd2}) begin err_cnt++; $display("FAIL rr_lines: got %h want 001002", ch_line); end
  endtask

  task automatic test_watermark();
    logic [AW-1:0] a; logic [CH-1:0] w, f; int cyc; logic seen;
    do_reset();
    ch_en = 2'b11; ch_fill = {10'd0, 10'd640};
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h100000) begin err_cnt++; $display("FAIL wm_skip_addr: got %h want 100000", a); end
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h100780) begin err_cnt++; $display("FAIL wm_skip_addr2: got %h want 100780", a); end
    vec_cnt++; if (w !== 2'b10) begin err_cnt++; $display("FAIL wm_skip_gnt: got %b want 10", w); end
    ch_en = 2'b01; ch_fill = {10'd0, 10'd400};
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen = seen | ddr_rreq; end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL wm_hyst_hold: got %b want 0", seen); end
    ch_fill = {10'd0, 10'd320};
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (cyc < 0 || cyc > 3) begin err_cnt++; $display("FAIL wm_resume_lat: got %0d want 0..3", cyc); end
    vec_cnt++; if (a !== 27'h0) begin err_cnt++; $display("FAIL wm_resume_addr: got %h want 0", a); end
  endtask

  task automatic test_rrdy_stall();
    int cyc; logic [AW-1:0] a; logic seen;
    do_reset();
    ch_en = 2'b01;
    wait_rreq(cyc);
    vec_cnt++; if (cyc < 0) begin err_cnt++; $display("FAIL stall_req: got timeout want rreq"); end
    a = ddr_raddr;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec_cnt++; if (ddr_rreq !== 1'b1 || ddr_raddr !== 27'h0) begin
        err_cnt++; $display("FAIL stall_hold%0d: got rreq=%b addr=%h want rreq=1 addr=0", i, ddr_rreq, ddr_raddr);
      end
    end
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    seen = 1'b0;
    for (int b = 0; b < LLEN; b++) begin ddr_rdata_en = 1'b1; tick(); seen = seen | ddr_rreq; end
    ddr_rdata_en = 1'b0;
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL stall_single: got %b want 0", seen); end
    vec_cnt++; if (a !== 27'h0) begin err_cnt++; $display("FAIL stall_addr: got %h want 0", a); end
    ddr_rdone = 1'b1; tick(); ddr_rdone = 1'b0;
    vec_cnt++; if (ch_line[11:0] !== 12'd1) begin err_cnt++; $display("FAIL stall_line: got %0d want 1", ch_line[11:0]); end
  endtask

  task automatic test_stale();
    logic [AW-1:0] a; logic [CH-1:0] w, f; int cyc; int wsum;
    do_reset();
    ch_en = 2'b10; ch_fsync = 2'b10; tick(); ch_fsync = 2'b00;
    wait_rreq(cyc);
    vec_cnt++; if (ddr_raddr !== 27'h180000) begin err_cnt++; $display("FAIL stale_bank1_addr: got %h want 180000", ddr_raddr); end
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    ch_frame_bit = 2'b10; ch_fsync = 2'b10;
    wsum = 0;
    for (int b = 0; b < LLEN; b++) begin
      ddr_rdata_en = 1'b1; #1; wsum += int'(ch_wr_en[1]); tick();
    end
    ddr_rdata_en = 1'b0; ddr_rdone = 1'b1; tick(); ddr_rdone = 1'b0;
    vec_cnt++; if (wsum !== 0) begin err_cnt++; $display("FAIL stale_wr_en: got %0d beats want 0", wsum); end
    vec_cnt++; if (ch_line[23:12] !== 12'd0) begin err_cnt++; $display("FAIL stale_line: got %0d want 0", ch_line[23:12]); end
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL stale_err: got %b want 0", err_overrun); end
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h100000) begin err_cnt++; $display("FAIL stale_newbank_addr: got %h want 100000", a); end
    vec_cnt++; if (w !== 2'b10) begin err_cnt++; $display("FAIL stale_next_wr: got %b want 10", w); end
    vec_cnt++; if (ch_line[23:12] !== 12'd1) begin err_cnt++; $display("FAIL stale_next_line: got %0d want 1", ch_line[23:12]); end
  endtask

  task automatic test_frame_done();
    logic [AW-1:0] a; logic [CH-1:0] w, f; int cyc; logic seen;
    do_reset();
    ch_en = 2'b01;
    for (int n = 0; n < 4; n++) begin
      serve(LLEN, a, w, f, cyc);
      vec_cnt++; if (f !== ((n == 3) ? 2'b01 : 2'b00)) begin
        err_cnt++; $display("FAIL fdone_line%0d: got %b want %b", n, f, (n == 3) ? 2'b01 : 2'b00);
      end
    end
    vec_cnt++; if (a !== 27'h1680) begin err_cnt++; $display("FAIL fdone_addr3: got %h want 1680", a); end
    tick();
    vec_cnt++; if (ch_frame_done !== 2'b00) begin err_cnt++; $display("FAIL fdone_pulse: got %b want 00", ch_frame_done); end
    vec_cnt++; if (ch_line[11:0] !== 12'd4) begin err_cnt++; $display("FAIL fdone_line: got %0d want 4", ch_line[11:0]); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen = seen | ddr_rreq; end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL fdone_quiet: got %b want 0", seen); end
    ch_fsync = 2'b01; tick(); ch_fsync = 2'b00;
    serve(LLEN, a, w, f, cyc);
    vec_cnt++; if (a !== 27'h80000) begin err_cnt++; $display("FAIL fdone_newframe_addr: got %h want 80000", a); end
  endtask

  task automatic test_overrun();
    int cyc; int wcount; logic last_wr;
    do_reset();
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_init: got %b want 0", err_overrun); end
    ddr_rdata_en = 1'b1; tick(); ddr_rdata_en = 1'b0;
    vec_cnt++; if (err_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_idle_beat: got %b want 1", err_overrun); end
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++; if (err_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky: got %b want 1", err_overrun); end
    do_reset();
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_rst_clear: got %b want 0", err_overrun); end
    ch_en = 2'b01;
    wait_rreq(cyc);
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    wcount = 0; last_wr = 1'b0;
    for (int b = 0; b <= LLEN; b++) begin
      ddr_rdata_en = 1'b1; #1;
      wcount += int'(ch_wr_en[0]);
      if (b == LLEN) last_wr = ch_wr_en[0];
      vec_cnt++; if (b < LLEN && err_overrun !== 1'b0) begin
        err_cnt++; $display("FAIL ovr_early%0d: got %b want 0", b, err_overrun);
      end
      tick();
    end
    ddr_rdata_en = 1'b0;
    vec_cnt++; if (last_wr !== 1'b0) begin err_cnt++; $display("FAIL ovr_extra_fwd: got %b want 0", last_wr); end
    vec_cnt++; if (wcount !== LLEN) begin err_cnt++; $display("FAIL ovr_fwd_count: got %0d want %0d", wcount, LLEN); end
    vec_cnt++; if (err_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_excess: got %b want 1", err_overrun); end
    ddr_rdone = 1'b1; tick(); ddr_rdone = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cyc;
    do_reset();
    ch_en = 2'b01;
    wait_rreq(cyc);
    vec_cnt++; if (ddr_rreq !== 1'b1) begin err_cnt++; $display("FAIL mrst_req: got %b want 1", ddr_rreq); end
    ddr_rst = 1'b1; tick();
    vec_cnt++; if (ddr_rreq !== 1'b0) begin err_cnt++; $display("FAIL mrst_drop: got %b want 0", ddr_rreq); end
    vec_cnt++; if (ddr_raddr !== '0) begin err_cnt++; $display("FAIL mrst_addr: got %h want 0", ddr_raddr); end
    ddr_rst = 1'b0;
    wait_rreq(cyc);
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL mrst_restart: got %0d want 2", cyc); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_watermark();
    test_rrdy_stall();
    test_stale();
    test_frame_done();
    test_overrun();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
